asg_segment_queue: RTL and testbench
====================================

ASG_SEGMENT_QUEUE -- requirements
Module: asg_segment_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queued motion segments (power of two, 2..16).
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 seg_dt_val  in  32  segment initial dt value.
REQ-005 seg_steps_val  in  32  segment step count.
REQ-006 seg_ctrl  in  4  {reset_dt, reset_steps, set_dt_limit, set_steps_limit}, bit0 = set_steps_limit.
REQ-007 seg_push  in  1  one-cycle strobe; enqueue seg_* fields.
REQ-008 start  in  1  one-cycle strobe; begin executing queued segments.
REQ-009 abort  in  1  one-cycle strobe; stop sequencing and flush queue.
REQ-010 asg_done  in  1  step generator segment-complete pulse.
REQ-011 asg_abort  in  1  step generator fault pulse.
REQ-012 asg_dt_val, asg_steps_val  out  32 each  registered segment values to step generator.
REQ-013 asg_ctrl  out  4  registered control bits, same order as seg_ctrl.
REQ-014 asg_load  out  1  one-cycle load strobe to step generator.
REQ-015 count  out  $clog2(DEPTH)+1  queued entries; full, empty  out  1 each, derived from count.
REQ-016 busy  out  1  high in LOAD or RUN.
REQ-017 seq_done, fault, overflow  out  1 each  one-cycle pulses, intended for executor interrupt lines.

Function
REQ-018 Queue SHALL be a DEPTH-entry circular FIFO of 68-bit entries {ctrl, steps, dt}, wr/rd pointers wrap modulo DEPTH.
REQ-019 seg_push with full=0 SHALL write the entry and increment count next cycle; with full=1 SHALL drop the entry and pulse overflow next cycle, even if a pop occurs the same cycle.
REQ-020 Simultaneous accepted push and pop SHALL leave count unchanged.
REQ-021 States: IDLE, LOAD, RUN.
REQ-022 IDLE: start=1 and empty=0 -> LOAD; start with empty=1 ignored, no pulse.
REQ-023 LOAD (one cycle): asg_load=1, asg_dt_val/asg_steps_val/asg_ctrl hold head entry, head popped; -> RUN.
REQ-024 Latency: start sampled cycle N -> asg_load high cycle N+1; asg_done sampled cycle M with empty=0 -> asg_load high cycle M+1.
REQ-025 RUN: asg_done with empty=0 -> LOAD; asg_done with empty=1 -> IDLE and seq_done pulse next cycle; emptiness sampled before any same-cycle push (pushed entry stays queued, needs new start).
REQ-026 RUN: asg_abort -> flush queue (count=0), fault pulse next cycle, IDLE; asg_abort wins over simultaneous asg_done.
REQ-027 abort in any state -> flush queue, IDLE next cycle, no seq_done/fault; abort wins over start, seg_push, asg_done, asg_abort same cycle (push discarded).
REQ-028 asg_dt_val/asg_steps_val/asg_ctrl SHALL hold last loaded values outside LOAD; asg_done/asg_abort ignored in IDLE and LOAD.
REQ-029 start while busy SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, pointers 0, count 0, empty=1, full=0, busy=0, all pulses 0, asg_load 0, asg_dt_val/asg_steps_val/asg_ctrl 0.
REQ-031 Reset mid-RUN SHALL discard queued entries; no pulses on deassertion; first action after release requires new push and start.
REQ-032 Queue storage contents need not be reset.

Structure
REQ-033 State encoding, ctrl bit indices and entry width constant SHALL live in the shared valurap package.
REQ-034 FIFO storage and pointers SHALL be one sub-module, seg_fifo; sequencer FSM stays in asg_segment_queue.

Verification
REQ-035 Push 3 segments (dt=100/200/300, steps=10/20/30), start -> asg_load cycle after start with dt=100, steps=10; each asg_done -> next load one cycle later; after 3rd done seq_done pulses once, busy=0, count=0.
REQ-036 DEPTH=4: 5 pushes -> count=4, full=1, overflow pulses once, executed segments are the first four.
REQ-037 Start with empty queue -> no asg_load, no pulses, state IDLE.
REQ-038 Two segments queued, asg_abort during first RUN -> fault pulse, count=0, no second asg_load.
REQ-039 abort same cycle as asg_done with one entry queued -> IDLE, count=0, no asg_load, no seq_done.
REQ-040 rst_n low during RUN with 2 entries -> outputs at reset values within same cycle; after release start yields no asg_load.

Source files
------------

// File: rtl/valurap_pkg.sv
// Shared types and constants for the motion segment queue: entry layout, ctrl bit indices
// and sequencer state encoding.
package valurap_pkg;

  localparam int ENTRY_W = 68;

  localparam int CTRL_SET_STEPS_LIMIT = 0;
  localparam int CTRL_SET_DT_LIMIT    = 1;
  localparam int CTRL_RESET_STEPS     = 2;
  localparam int CTRL_RESET_DT        = 3;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] steps;
    logic [31:0] dt;
  } seg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_fifo.sv
// Circular segment FIFO; push/pop take effect next cycle, push while full is dropped
// even with a same-cycle pop, flush clears pointers and count and discards a same-cycle push.
module seg_fifo
  import valurap_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  seg_t          push_dat,
  input  logic          pop,
  output seg_t          head_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  seg_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ok    = push & ~full & ~flush;
  assign rd_ok    = pop & ~empty & ~flush;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/asg_segment_queue.sv
// Queues motion segments and feeds them to the step generator one load strobe at a time;
// asg_load follows start or asg_done by one cycle, and pushes into a full queue are dropped with an overflow pulse.
module asg_segment_queue
  import valurap_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   seg_dt_val,
  input  logic [31:0]   seg_steps_val,
  input  logic [3:0]    seg_ctrl,
  input  logic          seg_push,
  input  logic          start,
  input  logic          abort,
  input  logic          asg_done,
  input  logic          asg_abort,
  output logic [31:0]   asg_dt_val,
  output logic [31:0]   asg_steps_val,
  output logic [3:0]    asg_ctrl,
  output logic          asg_load,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          seq_done,
  output logic          fault,
  output logic          overflow
);

  state_t state;
  state_t state_nxt;
  seg_t   head_dat;
  logic   pop;
  logic   flush;
  logic   seq_done_nxt;
  logic   fault_nxt;

  seg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (seg_push),
    .push_dat ('{ctrl: seg_ctrl, steps: seg_steps_val, dt: seg_dt_val}),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign busy = (state != ST_IDLE);

  // The head is popped on the edge that enters LOAD, so it sits in the output registers during LOAD
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    flush        = 1'b0;
    seq_done_nxt = 1'b0;
    fault_nxt    = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
      flush     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !empty) begin
            state_nxt = ST_LOAD;
            pop       = 1'b1;
          end
        end
        ST_LOAD: state_nxt = ST_RUN;
        ST_RUN: begin
          if (asg_abort) begin
            state_nxt = ST_IDLE;
            flush     = 1'b1;
            fault_nxt = 1'b1;
          end else if (asg_done) begin
            if (!empty) begin
              state_nxt = ST_LOAD;
              pop       = 1'b1;
            end else begin
              state_nxt    = ST_IDLE;
              seq_done_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      asg_load      <= 1'b0;
      asg_dt_val    <= '0;
      asg_steps_val <= '0;
      asg_ctrl      <= '0;
      seq_done      <= 1'b0;
      fault         <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state    <= state_nxt;
      asg_load <= pop;
      seq_done <= seq_done_nxt;
      fault    <= fault_nxt;
      overflow <= seg_push & full & ~abort;
      if (pop) begin
        asg_dt_val    <= head_dat.dt;
        asg_steps_val <= head_dat.steps;
        asg_ctrl      <= head_dat.ctrl;
      end
    end
  end

endmodule

// File: tb/tb_asg_segment_queue.sv
// Bench for asg_segment_queue: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_asg_segment_queue;
  import valurap_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   seg_dt_val = '0;
  logic [31:0]   seg_steps_val = '0;
  logic [3:0]    seg_ctrl = '0;
  logic          seg_push = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          asg_done = 1'b0;
  logic          asg_abort = 1'b0;
  logic [31:0]   asg_dt_val;
  logic [31:0]   asg_steps_val;
  logic [3:0]    asg_ctrl;
  logic          asg_load;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;
  logic          seq_done;
  logic          fault;
  logic          overflow;

  asg_segment_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg_dt_val(seg_dt_val), .seg_steps_val(seg_steps_val), .seg_ctrl(seg_ctrl),
    .seg_push(seg_push), .start(start), .abort(abort),
    .asg_done(asg_done), .asg_abort(asg_abort),
    .asg_dt_val(asg_dt_val), .asg_steps_val(asg_steps_val), .asg_ctrl(asg_ctrl),
    .asg_load(asg_load), .count(count), .full(full), .empty(empty), .busy(busy),
    .seq_done(seq_done), .fault(fault), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending segments plus what the step generator holds
  seg_t  m_q[$];
  bit    m_busy, m_loading, m_seq, m_fault, m_ovf;
  seg_t  m_out;

  task automatic m_clear();
    m_q.delete();
    m_busy = 0; m_loading = 0; m_seq = 0; m_fault = 0; m_ovf = 0;
    m_out = '0;
  endtask

  task automatic m_update();
    int  sz0;
    bit  was_loading;
    bit  flushed;
    sz0 = m_q.size();
    was_loading = m_loading;
    m_loading = 0; m_seq = 0; m_fault = 0; m_ovf = 0;
    flushed = 0;
    if (abort) begin
      m_q.delete();
      m_busy = 0;
    end else begin
      if (!m_busy) begin
        if (start && sz0 > 0) begin
          m_out = m_q.pop_front(); m_busy = 1; m_loading = 1;
        end
      end else if (!was_loading) begin
        if (asg_abort) begin
          m_q.delete(); m_busy = 0; m_fault = 1; flushed = 1;
        end else if (asg_done) begin
          if (sz0 > 0) begin
            m_out = m_q.pop_front(); m_loading = 1;
          end else begin
            m_busy = 0; m_seq = 1;
          end
        end
      end
      if (seg_push) begin
        if (sz0 == DEPTH) m_ovf = 1;
        else if (!flushed) m_q.push_back('{ctrl: seg_ctrl, steps: seg_steps_val, dt: seg_dt_val});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
    seg_push = 0; start = 0; abort = 0; asg_done = 0; asg_abort = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    m_clear();
    rst_n = 1;
  endtask

  task automatic push_seg(input logic [31:0] dt, input logic [31:0] st, input logic [3:0] c);
    seg_push = 1; seg_dt_val = dt; seg_steps_val = st; seg_ctrl = c;
    tick();
  endtask

  typedef struct {
    logic        push;
    logic [31:0] dt;
    logic [31:0] steps;
    logic [3:0]  ctrl;
    logic        start;
    logic        done;
    logic        e_load;
    logic [31:0] e_dt;
    logic [31:0] e_steps;
    logic [3:0]  e_ctrl;
    int          e_count;
    logic        e_busy;
    logic        e_seq;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(logic p, logic [31:0] d, logic [31:0] s, logic [3:0] c, logic st, logic dn,
                              logic el, logic [31:0] ed, logic [31:0] es, logic [3:0] ec, int en,
                              logic eb, logic esq, logic eo);
    vec_t v;
    v.push = p; v.dt = d; v.steps = s; v.ctrl = c; v.start = st; v.done = dn;
    v.e_load = el; v.e_dt = ed; v.e_steps = es; v.e_ctrl = ec; v.e_count = en;
    v.e_busy = eb; v.e_seq = esq; v.e_ovf = eo;
    return v;
  endfunction

  vec_t tbl[26];

  initial begin
    // Three-segment sequence, then overflow with DEPTH=4 and execution of the first four
    tbl[0]  = mk(1, 100, 10, 4'h1, 0, 0,  0,   0,  0, 4'h0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 200, 20, 4'h2, 0, 0,  0,   0,  0, 4'h0, 2, 0, 0, 0);
    tbl[2]  = mk(1, 300, 30, 4'h4, 0, 0,  0,   0,  0, 4'h0, 3, 0, 0, 0);
    tbl[3]  = mk(0,   0,  0, 4'h0, 1, 0,  1, 100, 10, 4'h1, 2, 1, 0, 0);
    tbl[4]  = mk(0,   0,  0, 4'h0, 0, 0,  0, 100, 10, 4'h1, 2, 1, 0, 0);
    tbl[5]  = mk(0,   0,  0, 4'h0, 0, 1,  1, 200, 20, 4'h2, 1, 1, 0, 0);
    tbl[6]  = mk(0,   0,  0, 4'h0, 0, 0,  0, 200, 20, 4'h2, 1, 1, 0, 0);
    tbl[7]  = mk(0,   0,  0, 4'h0, 0, 1,  1, 300, 30, 4'h4, 0, 1, 0, 0);
    tbl[8]  = mk(0,   0,  0, 4'h0, 0, 0,  0, 300, 30, 4'h4, 0, 1, 0, 0);
    tbl[9]  = mk(0,   0,  0, 4'h0, 0, 1,  0, 300, 30, 4'h4, 0, 0, 1, 0);
    tbl[10] = mk(0,   0,  0, 4'h0, 0, 0,  0, 300, 30, 4'h4, 0, 0, 0, 0);
    tbl[11] = mk(1,  11, 22, 4'h8, 0, 0,  0, 300, 30, 4'h4, 1, 0, 0, 0);
    tbl[12] = mk(1,  12, 24, 4'h8, 0, 0,  0, 300, 30, 4'h4, 2, 0, 0, 0);
    tbl[13] = mk(1,  13, 26, 4'h8, 0, 0,  0, 300, 30, 4'h4, 3, 0, 0, 0);
    tbl[14] = mk(1,  14, 28, 4'h8, 0, 0,  0, 300, 30, 4'h4, 4, 0, 0, 0);
    tbl[15] = mk(1,  15, 30, 4'h8, 0, 0,  0, 300, 30, 4'h4, 4, 0, 0, 1);
    tbl[16] = mk(0,   0,  0, 4'h0, 0, 0,  0, 300, 30, 4'h4, 4, 0, 0, 0);
    tbl[17] = mk(0,   0,  0, 4'h0, 1, 0,  1,  11, 22, 4'h8, 3, 1, 0, 0);
    tbl[18] = mk(0,   0,  0, 4'h0, 0, 0,  0,  11, 22, 4'h8, 3, 1, 0, 0);
    tbl[19] = mk(0,   0,  0, 4'h0, 0, 1,  1,  12, 24, 4'h8, 2, 1, 0, 0);
    tbl[20] = mk(0,   0,  0, 4'h0, 0, 0,  0,  12, 24, 4'h8, 2, 1, 0, 0);
    tbl[21] = mk(0,   0,  0, 4'h0, 0, 1,  1,  13, 26, 4'h8, 1, 1, 0, 0);
    tbl[22] = mk(0,   0,  0, 4'h0, 0, 0,  0,  13, 26, 4'h8, 1, 1, 0, 0);
    tbl[23] = mk(0,   0,  0, 4'h0, 0, 1,  1,  14, 28, 4'h8, 0, 1, 0, 0);
    tbl[24] = mk(0,   0,  0, 4'h0, 0, 0,  0,  14, 28, 4'h8, 0, 1, 0, 0);
    tbl[25] = mk(0,   0,  0, 4'h0, 0, 1,  0,  14, 28, 4'h8, 0, 0, 1, 0);

    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(asg_load), 0);
    chk("rst_dt", asg_dt_val, 0);
    chk("rst_pulses", {29'd0, seq_done, fault, overflow}, 0);
    rst_n = 1;

    for (int i = 0; i < 26; i++) begin
      seg_push = tbl[i].push; seg_dt_val = tbl[i].dt; seg_steps_val = tbl[i].steps;
      seg_ctrl = tbl[i].ctrl; start = tbl[i].start; asg_done = tbl[i].done;
      tick();
      chk($sformatf("v%0d_load", i), 32'(asg_load), 32'(tbl[i].e_load));
      chk($sformatf("v%0d_dt", i), asg_dt_val, tbl[i].e_dt);
      chk($sformatf("v%0d_steps", i), asg_steps_val, tbl[i].e_steps);
      chk($sformatf("v%0d_ctrl", i), 32'(asg_ctrl), 32'(tbl[i].e_ctrl));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_count == DEPTH));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_count == 0));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_seq_done", i), 32'(seq_done), 32'(tbl[i].e_seq));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Start with an empty queue is ignored
    do_reset();
    start = 1; tick();
    chk("empty_start_load", 32'(asg_load), 0);
    chk("empty_start_busy", 32'(busy), 0);
    chk("empty_start_pulses", {29'd0, seq_done, fault, overflow}, 0);

    // Step generator fault during the first RUN flushes the second entry
    push_seg(32'd5, 32'd6, 4'h3);
    push_seg(32'd7, 32'd8, 4'h5);
    start = 1; tick();
    chk("fault_first_load", 32'(asg_load), 1);
    tick();
    asg_abort = 1; tick();
    chk("fault_pulse", 32'(fault), 1);
    chk("fault_count", 32'(count), 0);
    chk("fault_busy", 32'(busy), 0);
    asg_done = 1; tick();
    chk("fault_pulse_once", 32'(fault), 0);
    chk("fault_no_second_load", 32'(asg_load), 0);

    // abort wins over a same-cycle asg_done with one entry still queued
    push_seg(32'd9, 32'd10, 4'h1);
    push_seg(32'd11, 32'd12, 4'h2);
    start = 1; tick();
    tick();
    abort = 1; asg_done = 1; tick();
    chk("abort_done_load", 32'(asg_load), 0);
    chk("abort_done_seq", 32'(seq_done), 0);
    chk("abort_done_count", 32'(count), 0);
    chk("abort_done_busy", 32'(busy), 0);
    tick();
    chk("abort_done_quiet", {28'd0, asg_load, seq_done, fault, overflow}, 0);

    // Reset mid-RUN takes effect without waiting for a clock edge
    push_seg(32'd21, 32'd22, 4'h1);
    push_seg(32'd23, 32'd24, 4'h2);
    push_seg(32'd25, 32'd26, 4'h4);
    start = 1; tick();
    tick();
    chk("pre_rst_count", 32'(count), 2);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_dt", asg_dt_val, 0);
    chk("mid_rst_steps", asg_steps_val, 0);
    chk("mid_rst_ctrl", 32'(asg_ctrl), 0);
    @(negedge clk);
    rst_n = 1;
    m_clear();
    #1;
    start = 1; tick();
    chk("post_rst_load", 32'(asg_load), 0);
    chk("post_rst_pulses", {29'd0, seq_done, fault, overflow}, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      seg_push      = ($urandom_range(99) < 40);
      seg_dt_val    = $urandom;
      seg_steps_val = $urandom;
      seg_ctrl      = 4'($urandom);
      start         = ($urandom_range(99) < 15);
      abort         = ($urandom_range(99) < 3);
      asg_done      = ($urandom_range(99) < 30);
      asg_abort     = ($urandom_range(99) < 4);
      tick();
      chk("rnd_load", 32'(asg_load), 32'(m_loading));
      chk("rnd_dt", asg_dt_val, m_out.dt);
      chk("rnd_steps", asg_steps_val, m_out.steps);
      chk("rnd_ctrl", 32'(asg_ctrl), 32'(m_out.ctrl));
      chk("rnd_count", 32'(count), 32'(m_q.size()));
      chk("rnd_full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("rnd_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("rnd_busy", 32'(busy), 32'(m_busy));
      chk("rnd_seq_done", 32'(seq_done), 32'(m_seq));
      chk("rnd_fault", 32'(fault), 32'(m_fault));
      chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
